// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer, LSB-first, one bit per clock.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input selecting a-b instead of a+b.
module serial_add_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_sub;
  logic             w_s1;
  logic             w_c1;
  logic             w_c2;
  logic             w_bit;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;
`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  serial_add_ha u_ha0 (.i_x(r_sa[0]), .i_y(r_sb[0]), .o_s(w_s1), .o_c(w_c1));
  serial_add_ha u_ha1 (.i_x(w_s1), .i_y(r_c), .o_s(w_bit), .o_c(w_c2));
  assign w_carry  = w_c1 | w_c2;
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  // Result bits fill r_sa from the top as operand bits leave at the bottom,
  // so after WIDTH shifts r_sa holds the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sa    <= a;
        r_sb    <= w_sub ? ~b : b;
        r_c     <= w_sub;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        r_sa <= {w_bit, r_sa[WIDTH-1:1]};
        r_sb <= {1'b0, r_sb[WIDTH-1:1]};
        r_c  <= w_carry;
        if (w_last) begin
          r_sum   <= {w_bit, r_sa[WIDTH-1:1]};
          r_cout  <= w_carry;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  int         n_tests = 0;
  int         n_fail = 0;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
`endif
  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, then counts edges until done (lat=-1 on timeout).
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, output int lat, output int busy_cnt);
    start = 1'b1; a = va; b = vb;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    int lat, bc;
    run_op(8'h05, 8'h03, lat, bc);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_tests++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    n_tests++; if ({cout, sum} !== 9'h008) begin n_fail++; $display("FAIL basic_sum: got %b/%h expected 0/08", cout, sum); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    tick(); tick();
    n_tests++; if ({cout, sum} !== 9'h008) begin n_fail++; $display("FAIL basic_hold: got %b/%h expected 0/08", cout, sum); end
  endtask

  task automatic test_carry();
    int lat, bc;
    run_op(8'hFF, 8'h01, lat, bc);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL carry1_latency: got %0d expected 8", lat); end
    n_tests++; if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL carry1_sum: got %b/%h expected 1/00", cout, sum); end
    tick();
    run_op(8'hAA, 8'h55, lat, bc);
    n_tests++; if ({cout, sum} !== 9'h0FF) begin n_fail++; $display("FAIL carry2_sum: got %b/%h expected 0/ff", cout, sum); end
    tick();
  endtask

  task automatic test_start_during_busy();
    int dones = 0;
    start = 1'b1; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0;
    n_tests++; if ({cout, sum} !== 9'h0FF) begin n_fail++; $display("FAIL busy_sum_held_in_run: got %b/%h expected 0/ff", cout, sum); end
    for (int k = 0; k < 14; k++) begin
      if (done) dones++;
      tick();
    end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", dones); end
    n_tests++; if ({cout, sum} !== 9'h030) begin n_fail++; $display("FAIL busy_sum: got %b/%h expected 0/30", cout, sum); end
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    start = 1'b1; a = 8'h01; b = 8'h01;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 8", lat); end
    n_tests++; if ({cout, sum} !== 9'h002) begin n_fail++; $display("FAIL b2b_first_sum: got %b/%h expected 0/02", cout, sum); end
    a = 8'h80; b = 8'h80;
    tick();
    start = 1'b0;
    n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_restart: got busy/done %b expected 10", {busy, done}); end
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 9", lat); end
    n_tests++; if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL b2b_second_sum: got %b/%h expected 1/00", cout, sum); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    int lat, bc;
    start = 1'b1; a = 8'h7F; b = 8'h01;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++; if ({busy, done, cout, sum} !== 11'h000) begin n_fail++; $display("FAIL midrst_outputs: got busy/done/cout/sum %b%b%b/%h expected 000/00", busy, done, cout, sum); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) dones++;
      tick();
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones); end
    run_op(8'h02, 8'h02, lat, bc);
    n_tests++; if ({cout, sum} !== 9'h004) begin n_fail++; $display("FAIL midrst_next_sum: got %b/%h expected 0/04", cout, sum); end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat, bc;
    sub = 1'b1;
    run_op(8'h05, 8'h03, lat, bc);
    n_tests++; if ({cout, sum} !== 9'h102) begin n_fail++; $display("FAIL sub1: got %b/%h expected 1/02", cout, sum); end
    tick();
    run_op(8'h03, 8'h05, lat, bc);
    n_tests++; if ({cout, sum} !== 9'h0FE) begin n_fail++; $display("FAIL sub2: got %b/%h expected 0/fe", cout, sum); end
    sub = 1'b0;
    tick();
    run_op(8'h05, 8'h03, lat, bc);
    n_tests++; if ({cout, sum} !== 9'h008) begin n_fail++; $display("FAIL sub0_add: got %b/%h expected 0/08", cout, sum); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
